// File: rtl/interval_timer.sv
// -----------------------------------------------------------------------------
// interval_timer
//
// Work/rest interval timer driven by a 1 Hz square wave that is generated in
// the clk_in domain. A run consists of `rounds` work phases, each followed by
// an optional rest phase (skipped when rest_sec is 0). The run is followed by
// DONE, which holds until a restart or reset.
//
// Optional feature macro: INTERVAL_TIMER_BUZZER_EN
//   defined   : buzz pulses for BUZZ_TICKS ticks after every phase change.
//   undefined : buzz is tied low and no buzz counter is built.
//
// Parameters
//   BUZZ_TICKS  number of 1 Hz ticks buzz stays high per event (1..7)
//
// Ports
//   clk_in     in   1  40 MHz system clock, rising edge
//   reset      in   1  asynchronous active-high reset
//   clk_1Hz    in   1  1 Hz square wave (same clock domain)
//   start      in   1  single-cycle start/restart request
//   pause      in   1  single-cycle pause/resume toggle
//   work_sec   in   7  work phase length in seconds (clamped to 99)
//   rest_sec   in   7  rest phase length in seconds, 0 = no rest (clamped to 99)
//   rounds     in   4  number of work rounds, 1..15
//   state      out  2  IDLE=0, WORK=1, REST=2, DONE=3
//   paused     out  1  countdown frozen
//   sec_left   out  7  seconds remaining in current phase
//   round_num  out  4  current round, starting at 1
//   buzz       out  1  buzzer enable
//   done       out  1  high in DONE
// -----------------------------------------------------------------------------
module interval_timer #(
  parameter int unsigned BUZZ_TICKS = 1
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       clk_1Hz,
  input  logic       start,
  input  logic       pause,
  input  logic [6:0] work_sec,
  input  logic [6:0] rest_sec,
  input  logic [3:0] rounds,
  output logic [1:0] state,
  output logic       paused,
  output logic [6:0] sec_left,
  output logic [3:0] round_num,
  output logic       buzz,
  output logic       done
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WORK = 2'd1;
  localparam logic [1:0] ST_REST = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [6:0] SEC_MAX = 7'd99;

  // Limit a seconds value to the two-digit display range.
  function automatic logic [6:0] clamp_sec(input logic [6:0] value);
    logic [6:0] result;
    if (value > SEC_MAX) begin
      result = SEC_MAX;
    end else begin
      result = value;
    end
    return result;
  endfunction

  // Tick detection
  logic hz_r;
  logic tick_r;

  // Run state
  logic [1:0] state_r;
  logic       paused_r;
  logic [6:0] sec_r;
  logic [3:0] round_r;
  logic       done_r;
  logic [6:0] work_lat_r;
  logic [6:0] rest_lat_r;
  logic [3:0] rounds_lat_r;

  // Next-state values
  logic [1:0] state_s;
  logic       paused_s;
  logic [6:0] sec_s;
  logic [3:0] round_s;
  logic [6:0] work_lat_s;
  logic [6:0] rest_lat_s;
  logic [3:0] rounds_lat_s;

  logic       run_active_s;
  logic       start_ok_s;
  logic       advance_s;

  assign run_active_s = (state_r == ST_WORK) || (state_r == ST_REST);

  // A start is only honoured from IDLE/DONE with a usable configuration.
  assign start_ok_s = start && (work_sec != 7'd0) && (rounds != 4'd0) &&
                      ((state_r == ST_IDLE) || (state_r == ST_DONE));

  // A tick moves the countdown only while running and not frozen. The paused
  // value before any same-cycle toggle decides whether this tick counts.
  assign advance_s = tick_r && !paused_r && run_active_s;

  // Edge register resets high so a 1 Hz wave already high at reset release
  // is not mistaken for a fresh rising edge; tick is a registered pulse.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      hz_r   <= 1'b1;
      tick_r <= 1'b0;
    end else begin
      hz_r   <= clk_1Hz;
      tick_r <= clk_1Hz & ~hz_r;
    end
  end

  // Next-state logic for the phase sequencer.
  always_comb begin
    state_s      = state_r;
    paused_s     = paused_r;
    sec_s        = sec_r;
    round_s      = round_r;
    work_lat_s   = work_lat_r;
    rest_lat_s   = rest_lat_r;
    rounds_lat_s = rounds_lat_r;

    if (start_ok_s) begin
      // Start wins over pause and tick in the same cycle.
      work_lat_s   = clamp_sec(work_sec);
      rest_lat_s   = clamp_sec(rest_sec);
      rounds_lat_s = rounds;
      sec_s        = clamp_sec(work_sec);
      round_s      = 4'd1;
      paused_s     = 1'b0;
      state_s      = ST_WORK;
    end else if (run_active_s) begin
      if (pause) begin
        paused_s = ~paused_r;
      end else begin
        paused_s = paused_r;
      end

      if (advance_s) begin
        if (sec_r > 7'd1) begin
          sec_s = sec_r - 7'd1;
        end else begin
          case (state_r)
            ST_WORK: begin
              if (round_r == rounds_lat_r) begin
                state_s = ST_DONE;
                sec_s   = 7'd0;
              end else if (rest_lat_r == 7'd0) begin
                // No rest configured: straight into the next work round.
                round_s = round_r + 4'd1;
                sec_s   = work_lat_r;
              end else begin
                state_s = ST_REST;
                sec_s   = rest_lat_r;
              end
            end
            ST_REST: begin
              state_s = ST_WORK;
              round_s = round_r + 4'd1;
              sec_s   = work_lat_r;
            end
            default: begin
              state_s = state_r;
              sec_s   = sec_r;
            end
          endcase
        end
      end else begin
        sec_s = sec_r;
      end
    end else begin
      // IDLE/DONE without a valid start: everything holds.
      state_s = state_r;
    end
  end

  // Phase sequencer registers.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      paused_r     <= 1'b0;
      sec_r        <= 7'd0;
      round_r      <= 4'd0;
      done_r       <= 1'b0;
      work_lat_r   <= 7'd0;
      rest_lat_r   <= 7'd0;
      rounds_lat_r <= 4'd0;
    end else begin
      state_r      <= state_s;
      paused_r     <= paused_s;
      sec_r        <= sec_s;
      round_r      <= round_s;
      done_r       <= (state_s == ST_DONE);
      work_lat_r   <= work_lat_s;
      rest_lat_r   <= rest_lat_s;
      rounds_lat_r <= rounds_lat_s;
    end
  end

`ifdef INTERVAL_TIMER_BUZZER_EN
  localparam logic [2:0] BUZZ_LOAD = 3'(BUZZ_TICKS);

  logic [2:0] buzz_cnt_r;
  logic [2:0] buzz_cnt_s;
  logic       buzz_r;
  logic       phase_end_s;

  // Every phase boundary (WORK->REST, REST->WORK, WORK->WORK, WORK->DONE)
  // happens on a counted tick with one second left.
  assign phase_end_s = advance_s && (sec_r <= 7'd1);

  // Buzz counter: reload on a phase boundary, count down on unfrozen ticks,
  // and clear on a fresh start so a restart begins silent.
  always_comb begin
    if (start_ok_s) begin
      buzz_cnt_s = 3'd0;
    end else if (phase_end_s) begin
      buzz_cnt_s = BUZZ_LOAD;
    end else if (tick_r && !paused_r && (buzz_cnt_r != 3'd0)) begin
      buzz_cnt_s = buzz_cnt_r - 3'd1;
    end else begin
      buzz_cnt_s = buzz_cnt_r;
    end
  end

  // Buzz counter and registered buzz output, aligned with the state change.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      buzz_cnt_r <= 3'd0;
      buzz_r     <= 1'b0;
    end else begin
      buzz_cnt_r <= buzz_cnt_s;
      buzz_r     <= (buzz_cnt_s != 3'd0);
    end
  end

  assign buzz = buzz_r;
`else
  assign buzz = 1'b0;
`endif

  assign state     = state_r;
  assign paused    = paused_r;
  assign sec_left  = sec_r;
  assign round_num = round_r;
  assign done      = done_r;

endmodule

// File: tb/tb_interval_timer.sv
// -----------------------------------------------------------------------------
// tb_interval_timer
//
// Self-checking bench for interval_timer. Stimulus is applied at transaction
// level (start pulse, pause pulse, one full 1 Hz period) and after each
// transaction the DUT outputs are compared with a behavioural model that
// applies the timer rules directly. Honours INTERVAL_TIMER_BUZZER_EN.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_interval_timer;

  localparam int BT = 2;
  localparam int M_IDLE = 0;
  localparam int M_WORK = 1;
  localparam int M_REST = 2;
  localparam int M_DONE = 3;

  logic       clk_in = 1'b0;
  logic       reset = 1'b1;
  logic       clk_1Hz = 1'b0;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic [6:0] work_sec = 7'd0;
  logic [6:0] rest_sec = 7'd0;
  logic [3:0] rounds = 4'd0;
  logic [1:0] state;
  logic       paused;
  logic [6:0] sec_left;
  logic [3:0] round_num;
  logic       buzz;
  logic       done;

  int n_checks = 0;
  int n_fail = 0;

  // Model state
  int m_state, m_paused, m_sec, m_round, m_work, m_rest, m_rounds, m_buzz_left;

  interval_timer #(.BUZZ_TICKS(BT)) dut (
    .clk_in   (clk_in),
    .reset    (reset),
    .clk_1Hz  (clk_1Hz),
    .start    (start),
    .pause    (pause),
    .work_sec (work_sec),
    .rest_sec (rest_sec),
    .rounds   (rounds),
    .state    (state),
    .paused   (paused),
    .sec_left (sec_left),
    .round_num(round_num),
    .buzz     (buzz),
    .done     (done)
  );

  always #12.5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int clamp99(input int v);
    return (v > 99) ? 99 : v;
  endfunction

  task automatic m_reset();
    m_state = M_IDLE; m_paused = 0; m_sec = 0; m_round = 0;
    m_work = 0; m_rest = 0; m_rounds = 0; m_buzz_left = 0;
  endtask

  function automatic bit m_running();
    return (m_state == M_WORK) || (m_state == M_REST);
  endfunction

  task automatic m_start(input int w, input int r, input int n);
    if (!m_running() && w != 0 && n != 0) begin
      m_work = clamp99(w); m_rest = clamp99(r); m_rounds = n;
      m_state = M_WORK; m_sec = m_work; m_round = 1; m_paused = 0;
      m_buzz_left = 0;
    end
  endtask

  task automatic m_pause();
    if (m_running()) m_paused = 1 - m_paused;
  endtask

  task automatic m_tick();
    bit ev;
    ev = 0;
    if (m_paused == 0) begin
      if (m_running()) begin
        if (m_sec > 1) m_sec = m_sec - 1;
        else begin
          ev = 1;
          if (m_state == M_REST) begin
            m_state = M_WORK; m_round++; m_sec = m_work;
          end else if (m_round == m_rounds) begin
            m_state = M_DONE; m_sec = 0;
          end else if (m_rest == 0) begin
            m_round++; m_sec = m_work;
          end else begin
            m_state = M_REST; m_sec = m_rest;
          end
        end
      end
      if (ev) m_buzz_left = BT;
      else if (m_buzz_left > 0) m_buzz_left--;
    end
  endtask

  function automatic int m_buzz();
`ifdef INTERVAL_TIMER_BUZZER_EN
    return (m_buzz_left > 0) ? 1 : 0;
`else
    return 0;
`endif
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic verify(input string tag);
    check({tag, ".state"},     32'(state),     32'(m_state));
    check({tag, ".paused"},    32'(paused),    32'(m_paused));
    check({tag, ".sec_left"},  32'(sec_left),  32'(m_sec));
    check({tag, ".round_num"}, 32'(round_num), 32'(m_round));
    check({tag, ".done"},      32'(done),      32'((m_state == M_DONE) ? 1 : 0));
    check({tag, ".buzz"},      32'(buzz),      32'(m_buzz()));
  endtask

  task automatic do_reset();
    @(negedge clk_in);
    reset = 1'b1;
    #1;
    m_reset();
    verify("reset");
    cyc(2);
    reset = 1'b0;
    cyc(2);
  endtask

  task automatic do_start(input int w, input int r, input int n);
    work_sec = 7'(w); rest_sec = 7'(r); rounds = 4'(n);
    start = 1'b1;
    @(negedge clk_in);
    start = 1'b0;
    cyc(2);
    m_start(w, r, n);
  endtask

  task automatic do_pause();
    pause = 1'b1;
    @(negedge clk_in);
    pause = 1'b0;
    cyc(2);
    m_pause();
  endtask

  task automatic do_tick();
    clk_1Hz = 1'b1;
    cyc(3);
    clk_1Hz = 1'b0;
    cyc(3);
    m_tick();
  endtask

  // Expected sequence for work=3 rest=2 rounds=2, written out by hand.
  int seq_st[9]  = '{1, 1, 1, 2, 2, 1, 1, 1, 3};
  int seq_sec[9] = '{3, 2, 1, 2, 1, 3, 2, 1, 0};
  int seq_rn[9]  = '{1, 1, 1, 1, 1, 2, 2, 2, 2};

  initial begin
    m_reset();
    cyc(1);
    do_reset();

    // Basic run with rest phase, checked against literal values and model.
    do_start(3, 2, 2);
    for (int i = 0; i < 9; i++) begin
      if (i > 0) do_tick();
      check("seq.state", 32'(state), 32'(seq_st[i]));
      check("seq.sec", 32'(sec_left), 32'(seq_sec[i]));
      check("seq.round", 32'(round_num), 32'(seq_rn[i]));
      verify("seq");
    end
    // DONE holds its outputs through further ticks (buzz finishes counting).
    do_tick(); verify("done_hold1");
    do_tick(); verify("done_hold2");
    check("done_hold.done", 32'(done), 32'd1);

    // No rest phase: three back-to-back work rounds.
    do_start(2, 0, 3);
    verify("norest_start");
    for (int i = 0; i < 6; i++) begin
      do_tick();
      verify("norest");
      check("norest.never_rest", 32'(state == 2'd2), 32'd0);
    end
    check("norest.final_round", 32'(round_num), 32'd3);

    // Pause at sec_left=5, four ignored ticks, resume.
    do_start(10, 0, 1);
    repeat (5) do_tick();
    check("pause.at5", 32'(sec_left), 32'd5);
    do_pause(); verify("pause.on");
    for (int i = 0; i < 4; i++) begin
      do_tick(); verify("pause.frozen");
      check("pause.frozen_sec", 32'(sec_left), 32'd5);
    end
    do_pause(); verify("pause.off");
    do_tick(); verify("pause.resumed");
    check("pause.resumed_sec", 32'(sec_left), 32'd4);
    // Start inside a run is ignored.
    do_start(50, 5, 9); verify("start_ignored");

    // Clamping of rest to 99.
    do_reset();
    do_start(1, 110, 2);
    do_tick(); verify("clamp_rest");
    check("clamp_rest.sec", 32'(sec_left), 32'd99);

    // work=0 ignored; start+pause together from IDLE.
    do_reset();
    do_start(0, 3, 2); verify("work0");
    check("work0.state", 32'(state), 32'd0);
    work_sec = 7'd4; rest_sec = 7'd1; rounds = 4'd1;
    start = 1'b1; pause = 1'b1;
    @(negedge clk_in);
    start = 1'b0; pause = 1'b0;
    cyc(2);
    m_start(4, 1, 1);
    verify("start_pause");
    check("start_pause.paused", 32'(paused), 32'd0);
    do_tick(); verify("start_pause.tick");

    // Reset mid-REST, then first-high-sample tick suppression.
    do_start(4, 3, 2); // ignored, run in progress
    do_reset();
    do_start(1, 3, 2);
    do_tick(); verify("pre_rst_rest");
    check("pre_rst_rest.state", 32'(state), 32'd2);
    @(negedge clk_in);
    reset = 1'b1;
    #1;
    m_reset();
    verify("rst_mid_rest");
    clk_1Hz = 1'b1;
    cyc(2);
    work_sec = 7'd5; rest_sec = 7'd0; rounds = 4'd1;
    reset = 1'b0;
    start = 1'b1;
    @(negedge clk_in);
    start = 1'b0;
    cyc(5);
    m_start(5, 0, 1);
    verify("no_tick_after_rst");
    check("no_tick_after_rst.sec", 32'(sec_left), 32'd5);
    clk_1Hz = 1'b0;
    cyc(3);
    do_tick(); verify("tick_after_rst");

    // Randomised runs against the model.
    do_reset();
    for (int run = 0; run < 25; run++) begin
      int w, r, n;
      w = $urandom_range(1, 5);
      r = $urandom_range(0, 3);
      n = $urandom_range(1, 3);
      if ($urandom_range(0, 9) == 0) w = 0;
      if ($urandom_range(0, 9) == 0) n = 0;
      do_start(w, r, n);
      verify("rnd_start");
      for (int step = 0; step < 80 && m_running(); step++) begin
        int sel;
        sel = $urandom_range(0, 9);
        if (sel < 7) do_tick();
        else if (sel < 9) do_pause();
        else do_start($urandom_range(1, 99), $urandom_range(0, 99), $urandom_range(1, 15));
        verify("rnd_step");
      end
      if (m_paused != 0) begin
        do_pause(); verify("rnd_unpause");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/interval_timer.md
INTERVAL_TIMER -- requirements
Module: interval_timer

Interface
REQ-001 SHALL have parameter BUZZ_TICKS, default 1: number of 1 Hz ticks the buzz output stays high per event (1..7).
REQ-002 SHALL have port clk_in, input, 1: 40 MHz system clock; all logic on its rising edge.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port clk_1Hz, input, 1: divided 1 Hz square wave from the clock divider, generated in the clk_in domain.
REQ-005 SHALL have port start, input, 1: single-cycle start/restart request.
REQ-006 SHALL have port pause, input, 1: single-cycle pause/resume toggle request.
REQ-007 SHALL have port work_sec, input, 7: work-phase length in seconds.
REQ-008 SHALL have port rest_sec, input, 7: rest-phase length in seconds; 0 means no rest phase.
REQ-009 SHALL have port rounds, input, 4: number of work rounds, 1..15.
REQ-010 SHALL have port state, output, 2: IDLE=0, WORK=1, REST=2, DONE=3.
REQ-011 SHALL have port paused, output, 1: high while countdown is frozen.
REQ-012 SHALL have port sec_left, output, 7: seconds remaining in the current phase.
REQ-013 SHALL have port round_num, output, 4: current round, starting at 1.
REQ-014 SHALL have port buzz, output, 1: buzzer enable, gated downstream with the 2 kHz tone.
REQ-015 SHALL have port done, output, 1: high in DONE.

Function
REQ-016 SHALL register clk_1Hz once and generate a one-cycle tick on every detected 0->1 transition; tick is asserted in the cycle after the rising level is first sampled.
REQ-017 SHALL, on start in IDLE or DONE, latch work_sec, rest_sec, and rounds (values above 99 clamped to 99), set sec_left=work_sec, round_num=1, paused=0, and enter WORK on the next cycle.
REQ-018 SHALL ignore start when work_sec==0 or rounds==0, and SHALL ignore start in WORK and REST.
REQ-019 SHALL, in WORK/REST with paused=0, decrement sec_left by one per tick while sec_left>1.
REQ-020 SHALL, on a tick with sec_left==1 in WORK: if round_num==latched rounds, enter DONE with sec_left=0; else if latched rest_sec==0, increment round_num and reload work_sec in WORK; else enter REST with sec_left=rest_sec.
REQ-021 SHALL, on a tick with sec_left==1 in REST, increment round_num, enter WORK, and load sec_left=work_sec.
REQ-022 SHALL toggle paused on pause only in WORK/REST; ticks are ignored while paused=1; pause is ignored in IDLE/DONE.
REQ-023 SHALL give start priority over pause and over tick in the same cycle; input changes after start SHALL NOT affect the run in progress.
REQ-024 SHALL hold all outputs in DONE until start (restart per REQ-017) or reset.

Reset
REQ-025 SHALL, on reset, immediately set state=IDLE, paused=0, sec_left=0, round_num=0, buzz=0, done=0, clear the tick edge register and buzz counter, and abandon any run in progress.
REQ-026 SHALL suppress a tick on the first clk_1Hz sample after reset release (the edge register resets to the current-high-safe value 1).

Configuration
REQ-027 SHALL, with INTERVAL_TIMER_BUZZER_EN defined, assert buzz on the cycle following each WORK->REST, REST->WORK, WORK->WORK, or WORK->DONE transition and hold it for BUZZ_TICKS ticks; a new event restarts the count; pause freezes the count.
REQ-028 SHALL, without INTERVAL_TIMER_BUZZER_EN, tie buzz to 0 and omit the buzz counter logic.

Verification
REQ-029 SHALL cover: work=3, rest=2, rounds=2, start -> WORK 3,2,1 -> REST 2,1 -> WORK r2 3,2,1 -> DONE, done=1, sec_left=0.
REQ-030 SHALL cover: rest=0, rounds=3, work=2 -> three WORK phases, round_num 1->2->3, and REST is never entered.
REQ-031 SHALL cover: pause at sec_left=5, 4 ticks, then pause -> sec_left stays 5 while paused and resumes decrementing to 4 on the next tick.
REQ-032 SHALL cover: start with work=0 -> state stays IDLE; start and pause in the same cycle from IDLE -> WORK with paused=0.
REQ-033 SHALL cover: reset asserted mid-REST -> all outputs are at their reset values in the same cycle, and no tick occurs on the first high clk_1Hz sample after release.
REQ-034 SHALL cover: with the macro defined and BUZZ_TICKS=2 -> buzz is high for exactly 2 ticks after each transition; with the macro undefined -> buzz is always 0.
